uv_spi_rxq: RTL and testbench

// - RX queue for the SPI master: buffers words assembled by the SPI shift engine until the bus-side reader pops them.
// - The shift engine cannot be stalled, so the write side has no backpressure. The queue detects overflow,

---
 rtl/uv_spi_rxq.sv | 94 +++++++++
 tb/tb_uv_spi_rxq.sv | 138 +++++++++++++
 2 files changed

// File: rtl/uv_spi_rxq.sv
// RX queue for the SPI master: first-word-fall-through FIFO with no write backpressure,
// a fixed drop/overwrite overflow policy, a saturating lost-word counter and a watermark level.
module uv_spi_rxq #(
  parameter int QUE_AW   = 3,
  parameter int QUE_DP   = 2 ** QUE_AW,
  parameter int QUE_DW   = 32,
  parameter bit OVF_OVWR = 1'b0,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rcv_vld,
  input  logic [QUE_DW-1:0] rcv_dat,
  output logic              deq_rdy,
  input  logic              deq_vld,
  output logic [QUE_DW-1:0] deq_dat,
  input  logic              que_clr,
  output logic [QUE_AW:0]   que_len,
  input  logic [QUE_AW:0]   wm_lvl,
  output logic              wm_irq,
  output logic              ovf,
  input  logic              ovf_clr,
  output logic [CNT_W-1:0]  ovf_cnt
);

  localparam int PTR_W = QUE_AW + 1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  logic [QUE_DW-1:0] mem_q [QUE_DP];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic empty, full, pop, ovf_evt, do_wr, rd_adv;

  assign que_len = wr_ptr_q - rd_ptr_q;
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (que_len == PTR_W'(QUE_DP));
  assign pop     = deq_vld && !empty;

  // A full queue that is also popped this cycle accepts the push normally.
  assign ovf_evt = rcv_vld && full && !pop && !que_clr;
  assign do_wr   = rcv_vld && !que_clr && (!full || pop || OVF_OVWR);
  assign rd_adv  = !que_clr && (pop || (ovf_evt && OVF_OVWR));

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    if (que_clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_wr)  wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_adv) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    // A same-cycle overflow beats ovf_clr and restarts the count at one.
    if (ovf_evt) begin
      ovf_d = 1'b1;
      cnt_d = ovf_clr ? CNT_W'(1) : sat_inc(cnt_q);
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
      for (int i = 0; i < QUE_DP; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
      if (do_wr) mem_q[wr_ptr_q[QUE_AW-1:0]] <= rcv_dat;
    end
  end

  assign deq_rdy = !empty;
  assign deq_dat = mem_q[rd_ptr_q[QUE_AW-1:0]];
  assign wm_irq  = (wm_lvl != '0) && (que_len >= wm_lvl);
  assign ovf     = ovf_q;
  assign ovf_cnt = cnt_q;

endmodule

// File: tb/tb_uv_spi_rxq.sv
// Directed bench for uv_spi_rxq: drop-policy (u0) and overwrite-policy (u1) instances share stimulus.
module tb_uv_spi_rxq;

  logic        clk = 1'b0;
  logic        rst, rcv_vld, deq_vld, que_clr, ovf_clr;
  logic [31:0] rcv_dat;
  logic [3:0]  wm_lvl;

  logic        r0, r1, w0, w1, v0, v1;
  logic [31:0] d0, d1;
  logic [3:0]  l0, l1;
  logic [7:0]  c0, c1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  uv_spi_rxq #(.QUE_AW(3), .QUE_DP(8), .QUE_DW(32), .OVF_OVWR(1'b0), .CNT_W(8)) u0 (
    .clk(clk), .rst(rst), .rcv_vld(rcv_vld), .rcv_dat(rcv_dat), .deq_rdy(r0), .deq_vld(deq_vld),
    .deq_dat(d0), .que_clr(que_clr), .que_len(l0), .wm_lvl(wm_lvl), .wm_irq(w0), .ovf(v0),
    .ovf_clr(ovf_clr), .ovf_cnt(c0));

  uv_spi_rxq #(.QUE_AW(3), .QUE_DP(8), .QUE_DW(32), .OVF_OVWR(1'b1), .CNT_W(8)) u1 (
    .clk(clk), .rst(rst), .rcv_vld(rcv_vld), .rcv_dat(rcv_dat), .deq_rdy(r1), .deq_vld(deq_vld),
    .deq_dat(d1), .que_clr(que_clr), .que_len(l1), .wm_lvl(wm_lvl), .wm_irq(w1), .ovf(v1),
    .ovf_clr(ovf_clr), .ovf_cnt(c1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rcv_vld = 1'b0; deq_vld = 1'b0; que_clr = 1'b0; ovf_clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rcv_dat = '0; wm_lvl = '0;
    idle();
    step(); step();
    rst = 1'b0;
    chk("rst_rdy0", r0, 0);    chk("rst_rdy1", r1, 0);
    chk("rst_len0", l0, 0);    chk("rst_dat0", d0, 0);
    chk("rst_ovf0", v0, 0);    chk("rst_cnt0", c0, 0);
    chk("rst_irq0", w0, 0);    chk("rst_len1", l1, 0);

    // basic ordering
    rcv_vld = 1'b1; rcv_dat = 32'hA1; step();
    chk("p1_len", l0, 1); chk("p1_dat", d0, 32'hA1); chk("p1_rdy", r0, 1);
    rcv_dat = 32'hA2; step();
    chk("p2_len", l0, 2); chk("p2_dat", d0, 32'hA1);
    rcv_dat = 32'hA3; step();
    chk("p3_len", l0, 3); chk("p3_dat", d0, 32'hA1);
    rcv_vld = 1'b0; deq_vld = 1'b1; step();
    chk("q1_len", l0, 2); chk("q1_dat", d0, 32'hA2);
    step();
    chk("q2_len", l0, 1); chk("q2_dat", d0, 32'hA3);
    step();
    chk("q3_len", l0, 0); chk("q3_rdy", r0, 0);
    step();
    chk("pop_empty_len", l0, 0); chk("pop_empty_len1", l1, 0);
    idle();

    // watermark
    wm_lvl = 4'd4;
    rcv_vld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rcv_dat = 32'h10 + i; step();
      chk("wm_push", w0, (i == 3) ? 1 : 0);
    end
    rcv_vld = 1'b0; deq_vld = 1'b1; step();
    chk("wm_pop_irq", w0, 0); chk("wm_pop_len", l0, 3);
    deq_vld = 1'b0; rcv_vld = 1'b1; rcv_dat = 32'h14; step();
    chk("wm_again", w0, 1);
    wm_lvl = 4'd0; rcv_vld = 1'b0; #1;
    chk("wm_dis0", w0, 0); chk("wm_dis1", w1, 0);
    que_clr = 1'b1; step(); idle();
    chk("clr_len0", l0, 0); chk("clr_len1", l1, 0);

    // overflow policies
    rcv_vld = 1'b1;
    for (int i = 0; i < 8; i++) begin rcv_dat = 32'h100 + i; step(); end
    chk("full_len0", l0, 8); chk("full_ovf0", v0, 0);
    rcv_dat = 32'hDEAD; step();
    chk("ovf_len0", l0, 8); chk("ovf_ovf0", v0, 1); chk("ovf_cnt0", c0, 1);
    chk("ovf_len1", l1, 8); chk("ovf_ovf1", v1, 1); chk("ovf_cnt1", c1, 1);
    rcv_vld = 1'b0; deq_vld = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drop_dat", d0, 32'h100 + i);
      chk("ovwr_dat", d1, (i == 7) ? 32'hDEAD : 32'h101 + i);
      step();
    end
    chk("drain_len0", l0, 0); chk("drain_len1", l1, 0);
    idle(); ovf_clr = 1'b1; step(); idle();
    chk("oclr_ovf0", v0, 0); chk("oclr_cnt1", c1, 0);

    // full with simultaneous push and pop
    rcv_vld = 1'b1;
    for (int i = 0; i < 8; i++) begin rcv_dat = 32'h200 + i; step(); end
    rcv_dat = 32'h2FF; deq_vld = 1'b1; step(); deq_vld = 1'b0;
    chk("pp_ovf0", v0, 0); chk("pp_ovf1", v1, 0);
    chk("pp_len0", l0, 8); chk("pp_dat0", d0, 32'h201); chk("pp_dat1", d1, 32'h201);

    // counter saturation
    for (int i = 0; i < 300; i++) begin rcv_dat = 32'h300 + i; step(); end
    chk("sat_cnt0", c0, 255); chk("sat_cnt1", c1, 255); chk("sat_ovf0", v0, 1);
    chk("sat_dat0", d0, 32'h201); chk("sat_dat1", d1, 32'h300 + 292); chk("sat_len1", l1, 8);

    // ovf_clr racing an overflow
    ovf_clr = 1'b1; rcv_dat = 32'h555; step(); ovf_clr = 1'b0;
    chk("race_cnt0", c0, 1); chk("race_ovf0", v0, 1); chk("race_cnt1", c1, 1);

    // que_clr with a push into a full queue
    que_clr = 1'b1; step(); idle();
    chk("qc_len0", l0, 0); chk("qc_len1", l1, 0); chk("qc_rdy0", r0, 0);
    chk("qc_cnt0", c0, 1); chk("qc_ovf1", v1, 1);

    // reset mid-traffic
    rcv_vld = 1'b1; rcv_dat = 32'h777; step();
    chk("pre_rst_dat", d0, 32'h777);
    rst = 1'b1; deq_vld = 1'b1; step(); rst = 1'b0; idle();
    chk("mr_len0", l0, 0); chk("mr_dat0", d0, 0); chk("mr_dat1", d1, 0);
    chk("mr_cnt0", c0, 0); chk("mr_ovf1", v1, 0); chk("mr_rdy1", r1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
